// File: rtl/reed_speed_if.sv
// Reed speed unit bus: raw reed/circumference inputs and the cleaned pulse,
// speed and status outputs of the front-end stage.
//   reed       raw reed contact level (asynchronous to clock)
//   circ       wheel circumference in cm
//   reed_pulse one-cycle pulse per accepted revolution
//   speed      current speed in km/h, 0..99
//   speed_upd  one-cycle pulse when speed is rewritten
//   moving     high while the wheel turns at >= 3 km/h
//   busy       divider active
// master drives reed/circ (sensor side), slave is the speed unit.
interface reed_speed_if;
  logic       reed;
  logic [7:0] circ;
  logic       reed_pulse;
  logic [6:0] speed;
  logic       speed_upd;
  logic       moving;
  logic       busy;

  modport master (
    output reed, circ,
    input  reed_pulse, speed, speed_upd, moving, busy
  );

  modport slave (
    input  reed, circ,
    output reed_pulse, speed, speed_upd, moving, busy
  );
endinterface

// File: rtl/reed_speed_unit.sv
// Bicycle computer front end: synchronises and debounces the reed contact,
// emits one pulse per wheel revolution, measures the revolution period and
// converts it to km/h with a bit-serial restoring divider. Also produces the
// 'moving' flag with a 3 km/h stop timeout.
// Ports:
//   clock     system clock (F_CLK Hz)
//   reset_in  asynchronous active-high reset
//   bus       reed_speed_if slave: reed, circ in; reed_pulse, speed,
//             speed_upd, moving, busy out
module reed_speed_unit #(
  parameter int F_CLK         = 2048,
  parameter int DEBOUNCE_CLKS = 8,
  parameter int CNT_W         = 16
) (
  input logic         clock,
  input logic         reset_in,
  reed_speed_if.slave bus
);

  // speed = circ[cm] * 36 * F_CLK / (1000 * P) = circ*N_MUL / (P*D_MUL)
  localparam int N_MUL = F_CLK * 9 / 2;
  localparam int D_MUL = 125;
  // 3 km/h threshold on the running count: cnt*D_MUL > circ*T_MUL
  localparam int T_MUL = F_CLK * 3 / 2;
  localparam int DEB_W = $clog2(DEBOUNCE_CLKS + 1);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_MEASURE = 2'd1;
  localparam logic [1:0] ST_DIVIDE  = 2'd2;

  // ---------------- synchroniser and debounce ----------------
  logic             sync1, sync2, hist;
  logic             pulse;
  logic [DEB_W-1:0] deb;
  logic             edge_ok;

  assign edge_ok = sync2 & ~hist & (deb == '0);

  always_ff @(posedge clock or posedge reset_in) begin
    if (reset_in) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      hist  <= 1'b0;
      pulse <= 1'b0;
      deb   <= '0;
    end else begin
      sync1 <= bus.reed;
      sync2 <= sync1;
      hist  <= sync2;
      pulse <= edge_ok;
      if (edge_ok)
        deb <= DEB_W'(DEBOUNCE_CLKS);
      else if (deb != '0)
        deb <= deb - DEB_W'(1);
    end
  end

  // ---------------- period measurement and divider ----------------
  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [7:0]       circ_reg;
  logic [6:0]       speed_reg;
  logic             speed_upd_reg;
  logic             moving_reg;
  logic [21:0]      n_sh, pend_n, n_new;
  logic [22:0]      d_reg, pend_d, d_new;
  logic [22:0]      rem, rem_nx;
  logic [20:0]      quo;
  logic [21:0]      quo_nx;
  logic [4:0]       bit_cnt;
  logic             pend;
  logic [23:0]      rem_sh;
  logic             ge;
  logic [6:0]       sat;
  logic             timeout;

  // Operands for a period ending now: P = cnt + 1.
  assign n_new = 22'(bus.circ) * 22'(N_MUL);
  assign d_new = (23'(cnt) + 23'd1) * 23'(D_MUL);

  // Threshold uses the circumference latched at the last pulse so that a
  // mid-period circ change does not move the stop point.
  assign timeout = (24'(cnt) * 24'(D_MUL)) > (24'(circ_reg) * 24'(T_MUL));

  // One restoring step: shift in the next dividend bit, subtract if it fits.
  assign rem_sh = {rem, n_sh[21]};
  assign ge     = rem_sh >= {1'b0, d_reg};
  assign rem_nx = ge ? 23'(rem_sh - {1'b0, d_reg}) : rem_sh[22:0];
  assign quo_nx = {quo, ge};
  assign sat    = (quo_nx > 22'd99) ? 7'd99 : quo_nx[6:0];

  always_ff @(posedge clock or posedge reset_in) begin
    if (reset_in) begin
      state         <= ST_IDLE;
      cnt           <= '0;
      circ_reg      <= '0;
      speed_reg     <= '0;
      speed_upd_reg <= 1'b0;
      moving_reg    <= 1'b0;
      n_sh          <= '0;
      d_reg         <= '0;
      rem           <= '0;
      quo           <= '0;
      bit_cnt       <= '0;
      pend          <= 1'b0;
      pend_n        <= '0;
      pend_d        <= '0;
    end else begin
      speed_upd_reg <= 1'b0;

      if (pulse) begin
        cnt      <= '0;
        circ_reg <= bus.circ;
      end else if (state != ST_IDLE && cnt != '1) begin
        cnt <= cnt + CNT_W'(1);
      end

      case (state)
        ST_IDLE: begin
          if (pulse && bus.circ != 8'd0) begin
            state      <= ST_MEASURE;
            moving_reg <= 1'b1;
          end
        end

        ST_MEASURE: begin
          if (pulse) begin
            if (bus.circ == 8'd0) begin
              state         <= ST_IDLE;
              speed_reg     <= '0;
              moving_reg    <= 1'b0;
              speed_upd_reg <= 1'b1;
            end else begin
              state   <= ST_DIVIDE;
              n_sh    <= n_new;
              d_reg   <= d_new;
              rem     <= '0;
              quo     <= '0;
              bit_cnt <= '0;
            end
          end else if (timeout) begin
            state         <= ST_IDLE;
            speed_reg     <= '0;
            moving_reg    <= 1'b0;
            speed_upd_reg <= 1'b1;
          end
        end

        ST_DIVIDE: begin
          // A pulse outranks the timeout; a zero circumference or a stop
          // aborts the divide and drops any pending operands.
          if ((pulse && bus.circ == 8'd0) || (!pulse && timeout)) begin
            state         <= ST_IDLE;
            speed_reg     <= '0;
            moving_reg    <= 1'b0;
            speed_upd_reg <= 1'b1;
            pend          <= 1'b0;
          end else begin
            n_sh    <= {n_sh[20:0], 1'b0};
            rem     <= rem_nx;
            quo     <= quo_nx[20:0];
            bit_cnt <= bit_cnt + 5'd1;
            if (bit_cnt == 5'd21) begin
              speed_reg     <= sat;
              speed_upd_reg <= 1'b1;
              pend          <= 1'b0;
              // Chain straight into the next divide: a pulse landing on the
              // final step is the newest period, otherwise use the pending one.
              if (pulse) begin
                n_sh    <= n_new;
                d_reg   <= d_new;
                rem     <= '0;
                quo     <= '0;
                bit_cnt <= '0;
              end else if (pend) begin
                n_sh    <= pend_n;
                d_reg   <= pend_d;
                rem     <= '0;
                quo     <= '0;
                bit_cnt <= '0;
              end else begin
                state <= ST_MEASURE;
              end
            end else if (pulse) begin
              pend   <= 1'b1;
              pend_n <= n_new;
              pend_d <= d_new;
            end
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.reed_pulse = pulse;
  assign bus.speed      = speed_reg;
  assign bus.speed_upd  = speed_upd_reg;
  assign bus.moving     = moving_reg;
  assign bus.busy       = (state == ST_DIVIDE);

endmodule

// File: tb/tb_reed_speed_unit.sv
// Self-checking bench for reed_speed_unit: directed scenarios plus random
// reed traffic, compared every cycle against an event-level reference model.
module tb_reed_speed_unit;
  logic clock    = 1'b0;
  logic reset_in = 1'b1;
  always #5 clock = ~clock;

  reed_speed_if bus ();

  reed_speed_unit #(
    .F_CLK(2048),
    .DEBOUNCE_CLKS(8),
    .CNT_W(16)
  ) dut (
    .clock(clock),
    .reset_in(reset_in),
    .bus(bus)
  );

  int total    = 0;
  int bad      = 0;
  int cyc      = 0;
  int cur_circ = 0;
  int npulse   = 0;

  // Reference model state: sample history, time of last accepted edge,
  // expected outputs and the scheduled divide results.
  bit s0, s1, s2, s3;
  int last_acc;
  bit m_pulse, m_moving, m_upd, job_on, pend_on;
  int m_speed, job_at, job_val, pend_val, tp, cp;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic int speed_of(input int c, input int p);
    int q;
    q = (c * 9216) / (p * 125);
    return (q > 99) ? 99 : q;
  endfunction

  task automatic model_reset();
    s0 = 0; s1 = 0; s2 = 0; s3 = 0;
    last_acc = -100;
    m_pulse = 0; m_moving = 0; m_upd = 0; m_speed = 0;
    job_on = 0; pend_on = 0; job_at = 0; job_val = 0; pend_val = 0;
    tp = 0; cp = 0;
  endtask

  task automatic model_stop();
    m_moving = 0; m_speed = 0; m_upd = 1; job_on = 0; pend_on = 0;
  endtask

  // Advance the model over one clock edge; r/c are the inputs held across it.
  task automatic model_step(input bit r, input int c);
    int c0;
    int v;
    c0 = cyc;
    cyc++;
    m_upd = 0;
    if (m_moving) begin
      if (m_pulse) begin
        if (c == 0) begin
          model_stop();
        end else begin
          v = speed_of(c, c0 - tp);
          if (job_on) begin
            pend_on = 1; pend_val = v;
          end else begin
            job_on = 1; job_at = cyc + 22; job_val = v;
          end
          tp = c0; cp = c;
        end
      end else if ((c0 - tp - 1) * 125 > cp * 3072) begin
        model_stop();
      end
      if (job_on && cyc == job_at) begin
        m_speed = job_val; m_upd = 1;
        if (pend_on) begin
          job_at = cyc + 22; job_val = pend_val; pend_on = 0;
        end else begin
          job_on = 0;
        end
      end
    end else if (m_pulse && c != 0) begin
      m_moving = 1; tp = c0; cp = c;
    end
    // A rising sample is seen two edges later; it is accepted only if at
    // least DEBOUNCE_CLKS+1 samples have passed since the last accepted one.
    s3 = s2; s2 = s1; s1 = s0; s0 = r;
    m_pulse = s2 && !s3 && ((cyc - 2 - last_acc) >= 9);
    if (m_pulse) last_acc = cyc - 2;
  endtask

  task automatic tick(input bit r);
    bus.reed = r;
    bus.circ = 8'(cur_circ);
    @(posedge clock);
    model_step(r, cur_circ);
    @(negedge clock);
    check_val("reed_pulse", 32'(bus.reed_pulse), 32'(m_pulse));
    check_val("speed",      32'(bus.speed),      32'(m_speed));
    check_val("speed_upd",  32'(bus.speed_upd),  32'(m_upd));
    check_val("moving",     32'(bus.moving),     32'(m_moving));
    check_val("busy",       32'(bus.busy),       32'(job_on));
    if (bus.reed_pulse) npulse++;
    if (bus.speed_upd)
      $display("cycle %0d: speed_upd speed=%0d moving=%0d circ=%0d", cyc, bus.speed, bus.moving, cur_circ);
  endtask

  task automatic train(input int period, input int n, input int width);
    for (int k = 0; k < n; k++)
      for (int i = 0; i < period; i++)
        tick(i < width);
  endtask

  initial begin
    int p0;
    bus.reed = 1'b0;
    bus.circ = 8'd0;
    model_reset();
    repeat (3) @(posedge clock);
    @(negedge clock);
    check_val("rst_reed_pulse", 32'(bus.reed_pulse), 0);
    check_val("rst_speed",      32'(bus.speed),      0);
    check_val("rst_speed_upd",  32'(bus.speed_upd),  0);
    check_val("rst_moving",     32'(bus.moving),     0);
    check_val("rst_busy",       32'(bus.busy),       0);
    reset_in = 1'b0;

    // Steady 2048-clock period, then faster periods including the clamp.
    cur_circ = 255;
    train(2048, 4, 4);
    check_val("speed_2048", 32'(bus.speed), 9);
    check_val("moving_2048", 32'(bus.moving), 1);
    train(190, 4, 3);
    check_val("speed_190", 32'(bus.speed), 98);
    train(100, 4, 2);
    check_val("speed_100_clamp", 32'(bus.speed), 99);

    // Pulses stop: stop timeout.
    repeat (6400) tick(1'b0);
    check_val("stop_speed", 32'(bus.speed), 0);
    check_val("stop_moving", 32'(bus.moving), 0);

    // Bounce: edges at t, t+3, t+6 give one pulse, t+9 gives a second.
    cur_circ = 1;
    p0 = npulse;
    for (int k = 0; k < 3; k++) begin
      tick(1'b1); tick(1'b0); tick(1'b0);
    end
    tick(1'b1);
    repeat (30) tick(1'b0);
    check_val("bounce_pulses", npulse - p0, 2);

    // Pulse 10 clocks after one that started a divide: pending divide.
    cur_circ = 2;
    tick(1'b1); repeat (39) tick(1'b0);
    tick(1'b1); repeat (9) tick(1'b0);
    tick(1'b1); repeat (39) tick(1'b0);
    check_val("pending_speed", 32'(bus.speed), 14);
    repeat (80) tick(1'b0);

    // Reset in the middle of a divide.
    cur_circ = 255;
    train(190, 1, 2);
    tick(1'b1);
    repeat (5) tick(1'b0);
    check_val("busy_pre_reset", 32'(bus.busy), 1);
    reset_in = 1'b1;
    #1;
    check_val("mid_rst_speed",     32'(bus.speed),     0);
    check_val("mid_rst_speed_upd", 32'(bus.speed_upd), 0);
    check_val("mid_rst_moving",    32'(bus.moving),    0);
    check_val("mid_rst_busy",      32'(bus.busy),      0);
    @(posedge clock);
    @(negedge clock);
    reset_in = 1'b0;
    model_reset();
    train(190, 1, 2);
    check_val("post_rst_moving", 32'(bus.moving), 1);
    check_val("post_rst_speed",  32'(bus.speed),  0);

    // Random traffic: periods, pulse widths, bounce and mid-period circ changes.
    for (int k = 0; k < 40; k++) begin
      int period;
      int width;
      bit bounce;
      period = int'($urandom_range(9, 600));
      width  = int'($urandom_range(1, 3));
      bounce = ($urandom_range(0, 3) == 0);
      for (int i = 0; i < period; i++) begin
        if (i == period / 2)
          cur_circ = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 255));
        tick((i < width) || (bounce && (i == 4 || i == 7)));
      end
    end
    repeat (100) tick(1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
